policy_server: RTL and testbench

Policy-server endpoint on the P1500-style wrapper link of the IP firewall. It accepts a header request on `WSO`/`UpdateWR`, the same header the firewall sends on an access-cache miss. It scans a programmable policy table and returns the granted permission on `WSI`/`CaptureWR` using a four-phase handshake. The table is loaded by a configuration port, and the block keeps hit and miss statistics.

---
 rtl/policy_server.sv | 125 ++++++++++++
 tb/tb_policy_server.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/policy_server.sv
// Policy server for the firewall wrapper link. It scans a register-based policy table for a
// requested {ip, proc} key and returns the granted permission with a four-phase handshake.
module policy_server #(
  parameter int         DEPTH        = 8,
  parameter int         ADDR_W       = 3,
  parameter logic [1:0] DEFAULT_PERM = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       WSO,
  input  logic              UpdateWR,
  output logic [31:0]       WSI,
  output logic              CaptureWR,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [32:0]       cfg_wdata,
  output logic              cfg_ready,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  typedef struct packed {
    logic        valid;
    logic [14:0] ip;
    logic [14:0] pid;
    logic [1:0]  perm;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  entry_t            tbl [DEPTH];
  logic [29:0]       req;
  logic [ADDR_W-1:0] idx;
  logic              byp_en;
  logic [ADDR_W-1:0] byp_addr;
  entry_t            byp_entry;
  entry_t            cur;
  logic              match, last, wr;
  logic              unused_bits;

  assign unused_bits = ^WSO[1:0];

  // A write landing on the same edge a scan starts must stay invisible to that scan,
  // so the pre-write contents of that one entry are kept for its duration.
  assign cur       = (byp_en && idx == byp_addr) ? byp_entry : tbl[idx];
  assign match     = cur.valid && cur.ip == req[29:15] &&
                     (cur.pid == req[14:0] || cur.pid == 15'h7FFF);
  assign last      = idx == LAST;
  assign cfg_ready = state == IDLE;
  assign wr        = cfg_we && state == IDLE;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (UpdateWR) state_nxt = SCAN;
      SCAN:    if (match || last) state_nxt = HOLD;
      HOLD:    if (!UpdateWR) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Only valid bits are reset; the remaining fields are meaningless while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i].valid <= 1'b0;
    end else if (wr) begin
      tbl[cfg_addr] <= entry_t'(cfg_wdata);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      WSI       <= '0;
      CaptureWR <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      req       <= '0;
      idx       <= '0;
      byp_en    <= 1'b0;
      byp_addr  <= '0;
      byp_entry <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (UpdateWR) begin
            req       <= WSO[31:2];
            idx       <= '0;
            byp_en    <= cfg_we;
            byp_addr  <= cfg_addr;
            byp_entry <= tbl[cfg_addr];
          end
        end
        SCAN: begin
          if (match) begin
            WSI       <= {req, cur.perm};
            CaptureWR <= 1'b1;
            if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
          end else if (last) begin
            WSI       <= {req, DEFAULT_PERM};
            CaptureWR <= 1'b1;
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        HOLD: begin
          if (!UpdateWR) begin
            CaptureWR <= 1'b0;
            WSI       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_policy_server.sv
// Directed bench for policy_server: reset state, hit/miss latency, wildcard priority,
// dropped and same-edge config writes, early strobe release and mid-scan reset.
module tb_policy_server;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] WSO;
  logic        UpdateWR;
  logic [31:0] WSI;
  logic        CaptureWR;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [32:0] cfg_wdata;
  logic        cfg_ready;
  logic [15:0] hit_cnt, miss_cnt;

  int n_vec = 0;
  int n_err = 0;
  int lat;

  policy_server #(.DEPTH(8), .ADDR_W(3), .DEFAULT_PERM(2'b00)) dut (
    .clk(clk), .rst(rst), .WSO(WSO), .UpdateWR(UpdateWR), .WSI(WSI), .CaptureWR(CaptureWR),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [14:0] ip, input logic [14:0] pid,
                           input logic [1:0] perm);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = {1'b1, ip, pid, perm};
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Returns k where CaptureWR is first seen after edge Ek (E0 samples the request); -1 on timeout.
  task automatic do_req(input logic [14:0] ip, input logic [14:0] pid, output int k);
    WSO = {ip, pid, 2'b10}; UpdateWR = 1'b1; k = -1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      cfg_we = 1'b0;
      if (CaptureWR) begin k = n; break; end
    end
  endtask

  task automatic release_req();
    UpdateWR = 1'b0;
    @(posedge clk); #1;
    chk("rel_cap", {31'd0, CaptureWR}, 32'd0);
    chk("rel_wsi", WSI, 32'd0);
    chk("rel_rdy", {31'd0, cfg_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; WSO = '0; UpdateWR = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_wsi", WSI, 32'd0);
    chk("rst_cap", {31'd0, CaptureWR}, 32'd0);
    chk("rst_rdy", {31'd0, cfg_ready}, 32'd1);
    chk("rst_hit", {16'd0, hit_cnt}, 32'd0);
    chk("rst_miss", {16'd0, miss_cnt}, 32'd0);

    // empty table: miss after E8
    do_req(15'd3, 15'd3, lat);
    chk("empty_lat", lat, 32'd8);
    chk("empty_wsi", WSI, {15'd3, 15'd3, 2'b00});
    chk("empty_miss", {16'd0, miss_cnt}, 32'd1);
    release_req();

    cfg_write(3'd3, 15'd1, 15'd5, 2'd3);
    do_req(15'd1, 15'd5, lat);
    chk("e3_lat", lat, 32'd4);
    chk("e3_wsi", WSI, {15'd1, 15'd5, 2'b11});
    chk("e3_hit", {16'd0, hit_cnt}, 32'd1);
    release_req();

    do_req(15'd1, 15'd9, lat);
    chk("nomatch_lat", lat, 32'd8);
    chk("nomatch_wsi", WSI, {15'd1, 15'd9, 2'b00});
    chk("nomatch_miss", {16'd0, miss_cnt}, 32'd2);
    release_req();

    // wildcard at index 1 beats exact match at index 2
    cfg_write(3'd1, 15'd2, 15'h7FFF, 2'd1);
    cfg_write(3'd2, 15'd2, 15'd4, 2'd3);
    do_req(15'd2, 15'd4, lat);
    chk("wild_lat", lat, 32'd2);
    chk("wild_wsi", WSI, {15'd2, 15'd4, 2'b01});
    chk("wild_hit", {16'd0, hit_cnt}, 32'd2);
    release_req();

    // write during SCAN is dropped
    WSO = {15'd5, 15'd5, 2'b00}; UpdateWR = 1'b1;
    @(posedge clk); #1;
    chk("scan_rdy", {31'd0, cfg_ready}, 32'd0);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = {1'b1, 15'd6, 15'd6, 2'd2};
    @(posedge clk); #1;
    cfg_we = 1'b0;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      if (CaptureWR) begin lat = n; break; end
      @(posedge clk); #1;
    end
    chk("scan_done", {31'd0, CaptureWR}, 32'd1);
    release_req();
    do_req(15'd6, 15'd6, lat);
    chk("drop_lat", lat, 32'd8);
    chk("drop_wsi", WSI, {15'd6, 15'd6, 2'b00});
    chk("drop_miss", {16'd0, miss_cnt}, 32'd4);
    release_req();

    // write on the same edge a scan starts is not seen by that scan, but by the next
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = {1'b1, 15'd7, 15'd7, 2'd1};
    do_req(15'd7, 15'd7, lat);
    chk("same_lat", lat, 32'd8);
    chk("same_wsi", WSI, {15'd7, 15'd7, 2'b00});
    release_req();
    do_req(15'd7, 15'd7, lat);
    chk("after_lat", lat, 32'd1);
    chk("after_wsi", WSI, {15'd7, 15'd7, 2'b01});
    chk("after_cnt", {hit_cnt, miss_cnt}, {16'd3, 16'd5});
    release_req();

    do_req(15'd2, 15'd100, lat);
    chk("wild2_lat", lat, 32'd2);
    chk("wild2_wsi", WSI, {15'd2, 15'd100, 2'b01});
    release_req();

    // strobe dropped during SCAN: one-cycle pulse after E4
    WSO = {15'd1, 15'd5, 2'b00}; UpdateWR = 1'b1;
    @(posedge clk); #1;
    UpdateWR = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("early_e3", {31'd0, CaptureWR}, 32'd0);
    @(posedge clk); #1;
    chk("early_e4", {31'd0, CaptureWR}, 32'd1);
    chk("early_wsi", WSI, {15'd1, 15'd5, 2'b11});
    @(posedge clk); #1;
    chk("early_e5", {31'd0, CaptureWR}, 32'd0);
    chk("early_hit", {16'd0, hit_cnt}, 32'd5);

    // reset sampled at E2 of a scan
    WSO = {15'd1, 15'd5, 2'b00}; UpdateWR = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; UpdateWR = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_rdy", {31'd0, cfg_ready}, 32'd1);
    chk("mrst_cnt", {hit_cnt, miss_cnt}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("mrst_cap", {31'd0, CaptureWR}, 32'd0);
    do_req(15'd1, 15'd5, lat);
    chk("mrst_lat", lat, 32'd8);
    chk("mrst_wsi", WSI, {15'd1, 15'd5, 2'b00});
    chk("mrst_cnt2", {hit_cnt, miss_cnt}, {16'd0, 16'd1});
    release_req();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
